// File: rtl/led_matrix_scan_driver.sv
// Row-scanned driver for the 7x5 game LED matrix. It shows ships, hits, blinking
// misses and a blinking cursor, using inputs captured once per frame.
module led_matrix_scan_driver #(
  parameter int SCAN_DIV    = 1000,
  parameter int SLOW_FRAMES = 50,
  parameter int FAST_FRAMES = 12
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [34:0] m_po,
  input  logic [34:0] m_at,
  input  logic [2:0]  cur_row,
  input  logic [2:0]  cur_col,
  input  logic        show_ships,
  output logic [4:0]  row_sel,
  output logic [6:0]  col_out,
  output logic        frame_tick
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int SLOW_W = (SLOW_FRAMES > 1) ? $clog2(SLOW_FRAMES) : 1;
  localparam int FAST_W = (FAST_FRAMES > 1) ? $clog2(FAST_FRAMES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_FRAMES - 1);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_FRAMES - 1);
  localparam logic [2:0]        LAST_ROW  = 3'd4;

  // ST_START is the single cycle after reset release: it opens frame 0.
  typedef enum logic {
    ST_START,
    ST_SCAN
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [2:0]        row_idx, row_idx_nxt;
  logic [SLOW_W-1:0] slow_cnt;
  logic [FAST_W-1:0] fast_cnt;
  logic              slow_ph, fast_ph;
  logic              frame_start, row_load;

  logic [34:0] snap_po, snap_at;
  logic [2:0]  snap_cur_row, snap_cur_col;
  logic        snap_show;

  logic [6:0]  pixel_row;
  logic [5:0]  cell_idx;
  logic        cell_po, cell_at, cursor_on;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, regardless of the order of the statements.
  always_ff @(posedge clk) begin
    if (!clr) state <= ST_START;
    else      state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    row_load    = 1'b0;
    div_nxt     = div_cnt + 1'b1;
    row_idx_nxt = row_idx;
    unique case (state)
      ST_START: begin
        state_nxt   = ST_SCAN;
        frame_start = 1'b1;
        row_load    = 1'b1;
        div_nxt     = '0;
        row_idx_nxt = 3'd0;
      end
      ST_SCAN: begin
        if (div_cnt == DIV_LAST) begin
          row_load = 1'b1;
          div_nxt  = '0;
          // The row counter wraps explicitly; 5 is never produced.
          if (row_idx == LAST_ROW) begin
            row_idx_nxt = 3'd0;
            frame_start = 1'b1;
          end else begin
            row_idx_nxt = row_idx + 3'd1;
          end
        end
      end
      default: state_nxt = ST_START;
    endcase
  end

  // Column pattern for the row being driven, from the frame snapshot.
  always_comb begin
    pixel_row = '0;
    cell_idx  = '0;
    cell_po   = 1'b0;
    cell_at   = 1'b0;
    cursor_on = (snap_cur_row < 3'd5) && (snap_cur_col < 3'd7);
    for (int c = 0; c < 7; c++) begin
      cell_idx = 6'(c * 5 + 4) - 6'(row_idx);
      cell_po  = snap_po[cell_idx];
      cell_at  = snap_at[cell_idx];
      if (cursor_on && snap_cur_col == 3'(c) && snap_cur_row == row_idx)
        pixel_row[c] = fast_ph;
      else if (cell_at && cell_po)
        pixel_row[c] = 1'b1;
      else if (cell_at)
        pixel_row[c] = slow_ph;
      else if (cell_po && snap_show)
        pixel_row[c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      div_cnt      <= '0;
      row_idx      <= 3'd0;
      slow_cnt     <= '0;
      fast_cnt     <= '0;
      slow_ph      <= 1'b0;
      fast_ph      <= 1'b0;
      snap_po      <= '0;
      snap_at      <= '0;
      snap_cur_row <= 3'd0;
      snap_cur_col <= 3'd0;
      snap_show    <= 1'b0;
      row_sel      <= 5'b11111;
      col_out      <= '0;
      frame_tick   <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      row_idx    <= row_idx_nxt;
      frame_tick <= frame_start;

      // Inputs and blink phases change only at frame starts, so a frame is coherent.
      if (frame_start) begin
        snap_po      <= m_po;
        snap_at      <= m_at;
        snap_cur_row <= cur_row;
        snap_cur_col <= cur_col;
        snap_show    <= show_ships;
        if (slow_cnt == SLOW_LAST) begin
          slow_cnt <= '0;
          slow_ph  <= ~slow_ph;
        end else begin
          slow_cnt <= slow_cnt + 1'b1;
        end
        if (fast_cnt == FAST_LAST) begin
          fast_cnt <= '0;
          fast_ph  <= ~fast_ph;
        end else begin
          fast_cnt <= fast_cnt + 1'b1;
        end
      end

      // Columns go dark for the cycle in which the row drive moves, avoiding ghosting.
      if (row_load) begin
        row_sel <= ~(5'd1 << row_idx_nxt);
        col_out <= '0;
      end else begin
        col_out <= pixel_row;
      end
    end
  end

endmodule
